// File: rtl/storage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : storage_pkg
//  Description : Shared types and constants for the external-storage SPI
//                read path: default read opcode, frame length, reader FSM
//                state encoding and a byte-order helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package storage_pkg;

    // Standard serial-flash READ command (no dummy cycles).
    localparam logic [7:0] DEFAULT_READ_OPCODE = 8'h03;

    // opcode(8) + address(24) out, data(32) in.
    localparam int SPI_FRAME_BITS = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_OUT = 3'd1,
        SHIFT_IN  = 3'd2,
        RESP      = 3'd3,
        CS_HOLD   = 3'd4
    } spi_rd_state_t;

    // Bytes arrive first-byte-in-MSB of the shift register; the response
    // word is little-endian (first byte in [7:0]).
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage : storage_pkg
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sck_gen
//  Description : SPI serial-clock generator (CPOL=0). While enabled, a
//                half-period counter runs 0..CLK_DIV-1 and SCK toggles each
//                time it wraps. Rise/fall strobes are asserted in the cycle
//                whose clk edge will raise/lower SCK. Disabling returns SCK
//                low and clears the counter.
//  Ports       : clk     in  system clock
//                rst     in  synchronous active-high reset
//                i_en    in  run the generator
//                o_sck   out registered serial clock
//                o_rise  out next clk edge raises SCK
//                o_fall  out next clk edge lowers SCK
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);
    assign o_rise = i_en & w_wrap & ~r_sck;
    assign o_fall = i_en & w_wrap &  r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : spi_sck_gen
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_reader
//  Description : SPI mode-0 master that reads one 32-bit little-endian word
//                from serial flash: sends READ_OPCODE + 24-bit address MSB
//                first, then shifts in 4 bytes. Fixed 64 SCK rising edges
//                per transaction; accept -> rsp_valid = 128*CLK_DIV+2 cycles.
//  Ports       : clk        in   system clock (posedge)
//                rst        in   synchronous active-high reset
//                req_valid  in   read request present
//                req_ready  out  engine idle, request accepted on valid&ready
//                req_addr   in   [23:0] flash byte address
//                rsp_valid  out  one-cycle response strobe
//                rsp_data   out  [31:0] byte@addr in [7:0] .. addr+3 in [31:24]
//                spi_cs_n   out  chip select, active low
//                spi_sck    out  serial clock, idle low
//                spi_mosi   out  master out, changes on SCK fall / cs_n fall
//                spi_miso   in   master in, sampled on edge raising SCK
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_reader
    import storage_pkg::*;
#(
    parameter int         CLK_DIV        = 2,
    parameter int         CS_IDLE_CYCLES = 2,
    parameter logic [7:0] READ_OPCODE    = DEFAULT_READ_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int              HOLD_W    = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_IDLE_CYCLES - 1);
    localparam logic [5:0]      HALF_FRAME = 6'(SPI_FRAME_BITS / 2);

    spi_rd_state_t     r_state;
    logic [5:0]        r_bit_cnt;     // SCK rising edges seen, wraps to 0 after the 64th
    logic [30:0]       r_tx;          // bits still to send after the one on mosi
    logic [31:0]       r_rx;
    logic [1:0]        r_tail_cnt;    // cs_n hold-off after the last SCK fall
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_cs_n;
    logic              r_mosi;

    logic w_sck_en;
    logic w_rise;
    logic w_fall;

    // SCK runs through both shift phases; it stops once the tail starts so
    // the clock stays low while cs_n is still asserted.
    assign w_sck_en = (r_state == SHIFT_OUT) ||
                      ((r_state == SHIFT_IN) && (r_tail_cnt == 2'd0));

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_sck_en),
        .o_sck  (spi_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_tail_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_tx        <= {READ_OPCODE[6:0], req_addr};
                        r_mosi      <= READ_OPCODE[7];
                        r_cs_n      <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_rx        <= '0;
                        r_tail_cnt  <= '0;
                        r_state     <= SHIFT_OUT;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                SHIFT_OUT: begin
                    if (w_rise) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == HALF_FRAME) begin
                            r_mosi  <= 1'b0;
                            r_state <= SHIFT_IN;
                        end else begin
                            r_mosi <= r_tx[30];
                            r_tx   <= {r_tx[29:0], 1'b0};
                        end
                    end
                end

                SHIFT_IN: begin
                    if (w_rise) begin
                        r_rx      <= {r_rx[30:0], spi_miso};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                    if (r_tail_cnt != 2'd0) begin
                        if (r_tail_cnt == 2'd2) begin
                            r_cs_n      <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= byte_swap32(r_rx);
                            r_tail_cnt  <= '0;
                            r_state     <= RESP;
                        end else begin
                            r_tail_cnt <= r_tail_cnt + 2'd1;
                        end
                    end else if (w_fall && (r_bit_cnt == 6'd0)) begin
                        // Bit counter wrapped on the 64th rise, so this is
                        // the final falling edge of the frame.
                        r_tail_cnt <= 2'd1;
                    end
                end

                RESP: begin
                    r_hold_cnt <= '0;
                    r_state    <= CS_HOLD;
                end

                CS_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign spi_cs_n  = r_cs_n;
    assign spi_mosi  = r_mosi;

endmodule : spi_flash_reader
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_flash_reader
//  Description : Bench for spi_flash_reader. Two instances (CLK_DIV=2/
//                CS_IDLE=2 and CLK_DIV=1/CS_IDLE=1) share a behavioural flash
//                model that captures mosi on SCK rise and drives miso after
//                SCK fall. Expected responses are queued at issue and popped
//                by a monitor when rsp_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_reader;

    typedef struct {
        logic [31:0] data;
        logic [31:0] cmd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req_addr [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data [2];
    logic [1:0]  cs_n;
    logic [1:0]  sck;
    logic [1:0]  mosi;
    logic [1:0]  miso;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t        exp_q[$];
    logic [31:0] data_q[$];

    // flash model / monitor state per instance
    int          rise_cnt  [2];
    logic [31:0] cmd_sh    [2];
    logic [31:0] cur_data  [2];
    bit          prev_cs   [2];
    bit          prev_sck  [2];
    bit          prev_rdy  [2];
    bit          busy_rdy  [2];
    bit          have_rise [2];
    bit          pulse_pend[2];
    int          rise_cyc  [2];
    int          acc_cyc   [2];
    int          lat_exp   [2] = '{258, 130};
    int          gap_min   [2] = '{2, 1};

    always #5 clk = ~clk;

    spi_flash_reader #(
        .CLK_DIV        (2),
        .CS_IDLE_CYCLES (2),
        .READ_OPCODE    (8'h03)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_data  (rsp_data[0]),
        .spi_cs_n  (cs_n[0]),
        .spi_sck   (sck[0]),
        .spi_mosi  (mosi[0]),
        .spi_miso  (miso[0])
    );

    spi_flash_reader #(
        .CLK_DIV        (1),
        .CS_IDLE_CYCLES (1),
        .READ_OPCODE    (8'h03)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_data  (rsp_data[1]),
        .spi_cs_n  (cs_n[1]),
        .spi_sck   (sck[1]),
        .spi_mosi  (mosi[1]),
        .spi_miso  (miso[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Flash model + response monitor, evaluated mid-cycle.
    initial begin
        exp_t e;
        int   j;
        int   gap;
        miso = '0;
        for (int i = 0; i < 2; i++) begin
            prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_rdy[i] = 1'b0;
            rise_cnt[i] = 0; cmd_sh[i] = '0; cur_data[i] = '0; busy_rdy[i] = 1'b0;
            have_rise[i] = 1'b0; pulse_pend[i] = 1'b0; rise_cyc[i] = 0; acc_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_rdy[i] = 1'b0;
                    rise_cnt[i] = 0; have_rise[i] = 1'b0; pulse_pend[i] = 1'b0;
                    miso[i] = 1'b0;
                end else begin
                    if (prev_rdy[i] && !req_ready[i]) acc_cyc[i] = cyc;
                    prev_rdy[i] = req_ready[i];

                    if (pulse_pend[i]) begin
                        check("rsp_pulse_width", {31'd0, rsp_valid[i]}, 32'd0);
                        pulse_pend[i] = 1'b0;
                    end

                    if (rsp_valid[i]) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_rsp: inst %0d got data %h, required no response", i, rsp_data[i]);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_data", rsp_data[i], e.data);
                            check("latency", 32'(cyc - acc_cyc[i]), 32'(lat_exp[i]));
                            check("mosi_cmd", cmd_sh[i], e.cmd);
                            check("sck_rises", 32'(rise_cnt[i]), 32'd64);
                            check("ready_low_busy", {31'd0, busy_rdy[i]}, 32'd0);
                        end
                        pulse_pend[i] = 1'b1;
                    end

                    if (prev_cs[i] && !cs_n[i]) begin
                        rise_cnt[i] = 0; cmd_sh[i] = '0; busy_rdy[i] = 1'b0;
                        if (data_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL cs_fall_no_request: inst %0d got cs_n low, required idle", i);
                            cur_data[i] = '0;
                        end else begin
                            cur_data[i] = data_q.pop_front();
                        end
                        if (have_rise[i]) begin
                            gap = cyc - 1 - rise_cyc[i];
                            total++;
                            if (gap < gap_min[i]) begin
                                bad++;
                                $display("FAIL cs_idle_gap: inst %0d got %0d cycles, required >= %0d", i, gap, gap_min[i]);
                            end
                            have_rise[i] = 1'b0;
                        end
                    end
                    if (!prev_cs[i] && cs_n[i]) begin
                        rise_cyc[i]  = cyc;
                        have_rise[i] = 1'b1;
                    end

                    if (!cs_n[i]) begin
                        if (req_ready[i]) busy_rdy[i] = 1'b1;
                        if (sck[i] && !prev_sck[i]) begin
                            if (rise_cnt[i] < 32) cmd_sh[i] = {cmd_sh[i][30:0], mosi[i]};
                            rise_cnt[i]++;
                        end
                        if (!sck[i] && prev_sck[i] && rise_cnt[i] >= 32 && rise_cnt[i] < 64) begin
                            j = rise_cnt[i] - 32;
                            miso[i] = cur_data[i][8 * (j / 8) + 7 - (j % 8)];
                        end
                    end
                    prev_cs[i]  = cs_n[i];
                    prev_sck[i] = sck[i];
                end
            end
        end
    end

    task automatic issue(input int i, input logic [23:0] addr, input logic [31:0] data, input bit keep);
        exp_t e;
        bit   ok;
        e.data = data;
        e.cmd  = {8'h03, addr};
        exp_q.push_back(e);
        data_q.push_back(data);
        @(negedge clk);
        req_addr[i]  = addr;
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            if (req_ready[i]) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: inst %0d got req_ready=0, required 1 within 1000 cycles", i);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid[i] = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !pulse_pend[0] && !pulse_pend[1]) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got %0d pending responses, required 0", exp_q.size());
        end
    endtask

    initial begin
        bit ok;
        rst         = 1'b1;
        req_valid   = '0;
        req_addr[0] = '0;
        req_addr[1] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("rst_rsp_data",  rsp_data[0], 32'd0);
        check("rst_cs_n",      {31'd0, cs_n[0]}, 32'd1);
        check("rst_sck",       {31'd0, sck[0]}, 32'd0);
        check("rst_mosi",      {31'd0, mosi[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

        // Basic read: bytes EF,BE,AD,DE -> 0xDEADBEEF
        issue(0, 24'h001001, 32'hDEADBEEF, 1'b0);
        wait_done();

        // Second request held valid while the first is in flight
        issue(0, 24'h000000, 32'h04030201, 1'b1);
        issue(0, 24'hABCDEF, 32'h55AA00FF, 1'b0);
        wait_done();

        // Reset at SCK rise #20 aborts the transaction
        issue(0, 24'h123456, 32'h0BADF00D, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (rise_cnt[0] == 20) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL rise20_timeout: got %0d rises, required 20", rise_cnt[0]);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("abort_cs_n",      {31'd0, cs_n[0]}, 32'd1);
        check("abort_sck",       {31'd0, sck[0]}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("abort_rsp_data",  rsp_data[0], 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 24'h7FFFFF, 32'hCAFEF00D, 1'b0);
        wait_done();

        // Fastest timing on the second instance, top-of-memory address
        issue(1, 24'hFFFFFC, 32'h12345678, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_flash_reader
`default_nettype wire
